// File: rtl/end_page_ctrl.sv
// end_page_ctrl: game-over screen sequencer (result latch, BCD conversion, frame-synced display, blink, hold, restart).
// Defining END_TIME_EN adds a game_time input converted after the score and shown on time_bcd.
module end_page_ctrl #(
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 120
) (
  input  logic                  vga_clk,
  input  logic                  sys_rst,
  input  logic                  game_over,
  input  logic                  game_won,
  input  logic [SCORE_W-1:0]    score,
`ifdef END_TIME_EN
  input  logic [SCORE_W-1:0]    game_time,
`endif
  input  logic                  frame_start,
  input  logic                  key_start,
  output logic                  end_active,
  output logic                  result_won,
  output logic [4*DIGITS-1:0]   score_bcd,
`ifdef END_TIME_EN
  output logic [4*DIGITS-1:0]   time_bcd,
`endif
  output logic                  banner_on,
  output logic                  restart_req,
  output logic                  busy
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned SH_W    = BCD_W + SCORE_W;
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;
`ifdef END_TIME_EN
  localparam int unsigned CONV_CYCLES = 2 * SCORE_W;
`else
  localparam int unsigned CONV_CYCLES = SCORE_W;
`endif
  localparam int unsigned CC_W = $clog2(CONV_CYCLES + 1);
  localparam int unsigned FC_W = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BC_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_SYNC  = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_ARMED = 3'd4;
  localparam logic [2:0] S_EXIT  = 3'd5;

  // One double-dabble step over {bcd, binary}: correct nibbles >= 5, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] x);
    logic [SH_W-1:0] y;
    y = x;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (y[SCORE_W + 4*i +: 4] >= 4'd5)
        y[SCORE_W + 4*i +: 4] = y[SCORE_W + 4*i +: 4] + 4'd3;
    end
    return {y[SH_W-2:0], 1'b0};
  endfunction

  // Clamp to the largest displayable value so conversion yields all nines.
  function automatic logic [SH_W-1:0] sat_load(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] b;
    b = v;
    if (32'(v) > MAX_VAL) b = SCORE_W'(MAX_VAL);
    return {BCD_W'(0), b};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CC_W-1:0]  conv_cnt_q, conv_cnt_d;
  logic [SH_W-1:0]  score_sh_q, score_sh_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             key_q, key_d;
  logic             end_active_q, end_active_d;
  logic             result_won_q, result_won_d;
  logic [BCD_W-1:0] score_bcd_q, score_bcd_d;
  logic             banner_on_q, banner_on_d;
  logic             restart_req_q, restart_req_d;
  logic             busy_q, busy_d;
  logic             key_rise;
`ifdef END_TIME_EN
  logic [SH_W-1:0]  time_sh_q, time_sh_d;
  logic [BCD_W-1:0] time_bcd_q, time_bcd_d;
`endif

  assign key_rise = key_start & ~key_q;

  always_comb begin
    state_d       = state_q;
    conv_cnt_d    = conv_cnt_q;
    score_sh_d    = score_sh_q;
    frame_cnt_d   = frame_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    key_d         = key_start;
    end_active_d  = end_active_q;
    result_won_d  = result_won_q;
    score_bcd_d   = score_bcd_q;
    banner_on_d   = banner_on_q;
    restart_req_d = 1'b0;
`ifdef END_TIME_EN
    time_sh_d     = time_sh_q;
    time_bcd_d    = time_bcd_q;
`endif

    case (state_q)
      S_IDLE: begin
        frame_cnt_d = '0;
        key_d       = 1'b0;
        if (game_over) begin
          score_sh_d   = sat_load(score);
          result_won_d = game_won;
          score_bcd_d  = '0;
`ifdef END_TIME_EN
          time_sh_d    = sat_load(game_time);
          time_bcd_d   = '0;
`endif
          conv_cnt_d   = '0;
          state_d      = S_CONV;
        end
      end
      S_CONV: begin
`ifdef END_TIME_EN
        if (conv_cnt_q < CC_W'(SCORE_W)) score_sh_d = dd_step(score_sh_q);
        else                             time_sh_d  = dd_step(time_sh_q);
`else
        score_sh_d = dd_step(score_sh_q);
`endif
        if (conv_cnt_q == CC_W'(CONV_CYCLES - 1)) state_d = S_SYNC;
        else conv_cnt_d = conv_cnt_q + 1'b1;
      end
      S_SYNC: begin
        if (frame_start) begin
          score_bcd_d  = score_sh_q[SH_W-1 -: BCD_W];
`ifdef END_TIME_EN
          time_bcd_d   = time_sh_q[SH_W-1 -: BCD_W];
`endif
          end_active_d = 1'b1;
          banner_on_d  = 1'b1;
          frame_cnt_d  = '0;
          blink_cnt_d  = '0;
          state_d      = S_SHOW;
        end
      end
      S_SHOW: begin
        if (frame_start) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (frame_cnt_d == FC_W'(HOLD_FRAMES)) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (key_rise) begin
          restart_req_d = 1'b1;
          state_d       = S_EXIT;
        end
      end
      S_EXIT: begin
        if (frame_start) begin
          end_active_d = 1'b0;
          banner_on_d  = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Victory banner blinks while the page is up and not yet exiting.
    if ((state_q == S_SHOW || state_q == S_ARMED) && frame_start && result_won_q) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        banner_on_d = ~banner_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      conv_cnt_q    <= '0;
      score_sh_q    <= '0;
      frame_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      key_q         <= 1'b0;
      end_active_q  <= 1'b0;
      result_won_q  <= 1'b0;
      score_bcd_q   <= '0;
      banner_on_q   <= 1'b0;
      restart_req_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef END_TIME_EN
      time_sh_q     <= '0;
      time_bcd_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      conv_cnt_q    <= conv_cnt_d;
      score_sh_q    <= score_sh_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      key_q         <= key_d;
      end_active_q  <= end_active_d;
      result_won_q  <= result_won_d;
      score_bcd_q   <= score_bcd_d;
      banner_on_q   <= banner_on_d;
      restart_req_q <= restart_req_d;
      busy_q        <= busy_d;
`ifdef END_TIME_EN
      time_sh_q     <= time_sh_d;
      time_bcd_q    <= time_bcd_d;
`endif
    end
  end

  assign end_active  = end_active_q;
  assign result_won  = result_won_q;
  assign score_bcd   = score_bcd_q;
  assign banner_on   = banner_on_q;
  assign restart_req = restart_req_q;
  assign busy        = busy_q;
`ifdef END_TIME_EN
  assign time_bcd    = time_bcd_q;
`endif

endmodule

// File: tb/tb_end_page_ctrl.sv
// Scoreboard bench for end_page_ctrl: each game is planned up front (frame and key schedule),
// expected output changes are queued with their cycle, and a monitor compares every observed change.
module tb_end_page_ctrl;
  localparam int unsigned SCORE_W = 10;
  localparam int unsigned DIGITS  = 3;
  localparam int BLINK = 30;
  localparam int HOLD  = 120;
`ifdef END_TIME_EN
  localparam int CONV_LEN = 2 * SCORE_W;
`else
  localparam int CONV_LEN = SCORE_W;
`endif

  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic game_over = 1'b0;
  logic game_won = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic frame_start = 1'b0;
  logic key_start = 1'b0;
  logic end_active, result_won, banner_on, restart_req, busy;
  logic [4*DIGITS-1:0] score_bcd;
`ifdef END_TIME_EN
  logic [SCORE_W-1:0] game_time = '0;
  logic [4*DIGITS-1:0] time_bcd;
`endif

  end_page_ctrl dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .game_over   (game_over),
    .game_won    (game_won),
    .score       (score),
`ifdef END_TIME_EN
    .game_time   (game_time),
    .time_bcd    (time_bcd),
`endif
    .frame_start (frame_start),
    .key_start   (key_start),
    .end_active  (end_active),
    .result_won  (result_won),
    .score_bcd   (score_bcd),
    .banner_on   (banner_on),
    .restart_req (restart_req),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic busy;
    logic end_a;
    logic ban;
    logic rr;
    logic won;
    logic [4*DIGITS-1:0] bcd;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  bit   first = 1'b1;
  outs_t cur, prev;
  exp_t  ex;

  // Reference: decimal digits of the clamped score, computed arithmetically.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int s);
    int v;
    logic [4*DIGITS-1:0] r;
    v = (s > 10 ** DIGITS - 1) ? 10 ** DIGITS - 1 : s;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic push(input int c, input outs_t o);
    exp_t e;
    e.cyc = c;
    e.o   = o;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs; they are sampled at edge cyc+1.
  task automatic drive(input bit go, input bit won, input int sc, input bit fs, input bit key, input bit rst);
    game_over   = go;
    game_won    = won;
    score       = SCORE_W'(sc);
    frame_start = fs;
    key_start   = key;
    sys_rst     = rst;
    @(posedge vga_clk);
    #1;
  endtask

  // mode 0: clean press after the hold; 1: key held from before game_over through frame 200;
  // 2: stray key pulse in SHOW and a second game_over (score 5) that must be ignored.
  task automatic run_game(input int sc, input bit won, input int mode, input int wait_c,
                          input bit fs_last, input int abort_f);
    int g, ce, kf, nf, k, x, a, last, fi, kh;
    int F[$];
    outs_t o;
    bit go, fs, key;
    repeat (3) drive(1'b0, 1'b0, 0, 1'b0, (mode == 1), 1'b0);
    g  = cyc + 1;
    ce = g + CONV_LEN;
    kf = (mode == 1) ? 200 : ((mode == 2) ? HOLD + 1 : HOLD);
    nf = (abort_f > 0) ? abort_f : kf + 1;
    F.push_back(ce + 1 + wait_c);
    for (int n = 1; n <= nf; n++) F.push_back(F[n-1] + $urandom_range(4, 6));
    k = F[kf < nf ? kf : 0] + 2;
    x = F[(kf + 1) <= nf ? kf + 1 : 0];
    a = F[nf] + 1;
    kh = (mode == 2) ? F[40] + 1 : -1;

    o = '{busy: 1'b1, end_a: 1'b0, ban: 1'b0, rr: 1'b0, won: won, bcd: '0};
    push(g, o);
    o.end_a = 1'b1;
    o.ban   = 1'b1;
    o.bcd   = ref_bcd(sc);
    push(F[0], o);
    for (int n = 1; n <= ((abort_f > 0) ? abort_f : kf); n++) begin
      if (won && (n % BLINK == 0)) begin
        o.ban = ~o.ban;
        push(F[n], o);
      end
    end
    if (abort_f > 0) begin
      push(a, '0);
      last = a;
    end else begin
      o.rr = 1'b1; push(k, o);
      o.rr = 1'b0; push(k + 1, o);
      o.busy = 1'b0; o.end_a = 1'b0; o.ban = 1'b0;
      push(x, o);
      last = x + 2;
    end

    fi = 0;
    for (int e = g; e <= last; e++) begin
      go = (e == g) || (mode == 2 && e == F[10] + 1);
      fs = (e == g + 2) || (fs_last && e == ce);
      if (fi <= nf && e == F[fi]) begin
        fs = 1'b1;
        fi++;
      end
      if (abort_f > 0) key = 1'b0;
      else if (mode == 1) key = (e <= F[kf]) || (e >= k && e < k + 3);
      else key = (e == kh) || (e >= k && e < k + 3);
      drive(go, won, (e == g) ? sc : 5, fs, key, (abort_f > 0 && e == a));
    end
  endtask

  // Monitor: every change of the output vector must match the next queued expectation.
  always @(negedge vga_clk) begin
    if (mon_en) begin
      cur = {busy, end_active, banner_on, restart_req, result_won, score_bcd};
      if (first) begin
        n_cmp++;
        if (cur != '0) begin
          n_fail++;
          $display("FAIL reset_state: got %h want 0", cur);
        end
        first = 1'b0;
      end else if (cur != prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got busy=%b end=%b ban=%b rr=%b won=%b bcd=%h",
                   cyc, cur.busy, cur.end_a, cur.ban, cur.rr, cur.won, cur.bcd);
        end else begin
          ex = exp_q.pop_front();
          if (ex.cyc != cyc || ex.o != cur)
            begin
              n_fail++;
              $display("FAIL output_event got cyc=%0d busy=%b end=%b ban=%b rr=%b won=%b bcd=%h; want cyc=%0d busy=%b end=%b ban=%b rr=%b won=%b bcd=%h",
                       cyc, cur.busy, cur.end_a, cur.ban, cur.rr, cur.won, cur.bcd,
                       ex.cyc, ex.o.busy, ex.o.end_a, ex.o.ban, ex.o.rr, ex.o.won, ex.o.bcd);
            end
        end
      end
      prev = cur;
      if (done) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL missing_events: got %0d outstanding want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  initial begin
    repeat (3) drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    run_game(372, 1'b0, 0, 50, 1'b0, 0);
    run_game(57, 1'b1, 0, 5, 1'b0, 20);
    run_game(1023, 1'b0, 0, 3, 1'b1, 0);
    run_game(0, 1'b1, 0, 0, 1'b0, 0);
    run_game(999, 1'b1, 1, 7, 1'b0, 0);
    run_game(640, 1'b0, 2, 2, 1'b1, 0);
    for (int i = 0; i < 3; i++)
      run_game(int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 0,
               int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 0);
    repeat (5) drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    done = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/end_page_ctrl.md
Name: end_page_ctrl

Overview:
Sequencer for the game-over screen. Latches final score and win/lose result on a game-over event, converts the score to BCD over multiple cycles, switches the display to the end page only on a frame boundary, blinks the banner, and enforces a minimum display time before it accepts a restart. It sits between the game-logic core and the end-page pixel renderer. The renderer consumes its BCD digits, result and banner-enable outputs.

Parameters:
SCORE_W, 10, width of the binary score input
DIGITS, 3, number of BCD digits produced (max displayable value 10^DIGITS-1)
BLINK_FRAMES, 30, frames per banner on/off half-period (victory only)
HOLD_FRAMES, 120, frames the end page is shown before restart is accepted

Ports:
vga_clk  in  1  pixel/system clock; all logic on its rising edge
sys_rst  in  1  synchronous active-high reset
game_over  in  1  one-cycle pulse from game core: game has ended
game_won  in  1  result qualifier, sampled with game_over (1 = victory, 0 = died)
score  in  SCORE_W  final score, sampled with game_over
frame_start  in  1  one-cycle pulse at start of vertical blank
key_start  in  1  synchronised start/restart button level
end_active  out  1  renderer shows end page when 1
result_won  out  1  latched result
score_bcd  out  4*DIGITS  latched BCD score, most significant digit in the top nibble
banner_on  out  1  banner text enable
restart_req  out  1  one-cycle pulse to the game core
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, and any cycle with sys_rst=1, forces state IDLE and sets all outputs to 0. This includes score_bcd=0. A reset mid-conversion or mid-display drops everything immediately.
- States: IDLE, CONV, SYNC, SHOW, ARMED, EXIT.
- IDLE:
  - On game_over=1, latch score into a shift register and game_won into result_won, then go to CONV.
  - Also clear the frame counter and the key edge register.
- CONV (double-dabble, one shift per cycle):
  - Each cycle, add 3 to every BCD nibble >=5, then shift left by 1.
  - Runs exactly SCORE_W cycles, then goes to SYNC.
  - If the latched score is >10^DIGITS-1, the result saturates to all nines (e.g. 999). The saturation check is done at latch time.
- SYNC:
  - Wait for frame_start. A frame_start coincident with the last CONV cycle does not count.
  - On frame_start: load score_bcd, set end_active=1, set banner_on=1, clear the frame counter, go to SHOW.
- SHOW:
  - Count frame_start pulses.
  - Banner behaviour:
    - result_won=1: banner_on toggles every BLINK_FRAMES frames.
    - result_won=0: banner_on stays 1.
  - When the count reaches HOLD_FRAMES, go to ARMED.
- ARMED:
  - Blinking continues.
  - A rising edge on key_start (detected against the previous-cycle value, tracked in all states) asserts restart_req for exactly one cycle and goes to EXIT.
  - A key held since before ARMED does not trigger; a release and re-press is required.
- EXIT:
  - Hold outputs until the next frame_start.
  - On that frame_start: clear end_active and banner_on, keep score_bcd, go to IDLE.
  - score_bcd is cleared on the next game_over latch.
- game_over pulses outside IDLE are ignored.
- A key_start edge in SHOW is ignored and is not queued.
- busy=1 in every state except IDLE.
- Latency: game_over to end_active = 1 + SCORE_W + (cycles until the next frame_start) + 1.

Optional Feature:
Macro END_TIME_EN.
- Defined:
  - Adds input game_time [SCORE_W-1:0], sampled with game_over.
  - Adds output time_bcd [4*DIGITS-1:0].
  - CONV runs a second, sequential SCORE_W-cycle conversion for game_time, so CONV lasts 2*SCORE_W cycles.
  - time_bcd saturates and loads exactly like score_bcd.
- Undefined: the port is absent, CONV lasts SCORE_W cycles, and no extra logic is generated.

Test Plan:
- Reset during SHOW with score 57 displayed -> next cycle end_active=0, score_bcd=0, busy=0, state IDLE.
- game_over, game_won=0, score=10'd372; frame_start 50 cycles later -> score_bcd=12'h372 and end_active=1 on that frame_start cycle. banner_on stays 1 for 120 frames. Key press at frame 121 -> one-cycle restart_req; end_active=0 after the next frame_start.
- score=10'd1023 -> score_bcd=12'h999.
- game_won=1, score=0 -> score_bcd=12'h000. banner_on toggles every 30 frames (on 30, off 30, on 30).
- key_start held high from before game_over through frame 200 -> no restart_req. Release, then press -> restart_req pulses once.
- Second game_over during SHOW with score 5 -> ignored, score_bcd unchanged. frame_start on the final CONV cycle -> not used; the display loads on the following frame_start.
